// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream loader framing RV32I text/data images into word writes
// Optional build macro: LOADER_TIMEOUT_EN (inter-byte timeout, err_code 3).
module prog_loader #(
  parameter int unsigned TEXT_ORG       = 'h0,
  parameter int unsigned TEXT_LENGTH    = 'h400,
  parameter int unsigned DATA_ORG       = 'h500,
  parameter int unsigned DATA_LENGTH    = 'h400,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic        mem_seg,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_hold,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam logic [31:0] TEXT_ORG_W = 32'(TEXT_ORG);
  localparam logic [31:0] DATA_ORG_W = 32'(DATA_ORG);
  localparam logic [31:0] TEXT_LEN_W = 32'(TEXT_LENGTH);
  localparam logic [31:0] DATA_LEN_W = 32'(DATA_LENGTH);

  typedef enum logic [2:0] {
    S_IDLE, S_SEG, S_CNT_LO, S_CNT_HI, S_DATA, S_CHK
  } state_t;

  state_t      state, state_n;
  logic        seg;
  logic [15:0] cnt;
  logic [15:0] idx;
  logic [1:0]  bcnt;
  logic [23:0] word_lo;
  logic [7:0]  xsum;

  logic        do_write, do_done, do_err, hold_set;
  logic [1:0]  err_code_n;
  logic        timeout;
  logic [31:0] frame_bytes;
  logic [31:0] seg_limit;

  // The link is never back-pressured; memory takes one write per cycle.
  assign in_ready = 1'b1;

  // Requested byte count of the frame, available while the count high byte is on the bus.
  assign frame_bytes = {14'd0, in_data, cnt[7:0], 2'b00};
  assign seg_limit   = seg ? DATA_LEN_W : TEXT_LEN_W;

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] tcnt;

  // Counts idle cycles inside a frame; any accepted byte or return to IDLE restarts it.
  always_ff @(posedge clk) begin
    if (rst || state == S_IDLE || in_valid || timeout) tcnt <= 32'd0;
    else                                                tcnt <= tcnt + 32'd1;
  end

  assign timeout = (state != S_IDLE) && !in_valid && (tcnt == 32'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  // Frame parser: next state plus the one-cycle write/done/err decisions.
  always_comb begin
    state_n    = state;
    do_write   = 1'b0;
    do_done    = 1'b0;
    do_err     = 1'b0;
    err_code_n = 2'd0;
    hold_set   = 1'b0;
    if (timeout) begin
      do_err     = 1'b1;
      err_code_n = 2'd3;
      state_n    = S_IDLE;
    end else if (in_valid) begin
      case (state)
        S_IDLE: if (in_data == SYNC_BYTE) state_n = S_SEG;
        S_SEG: begin
          if (in_data[7:1] == 7'd0) begin
            state_n = S_CNT_LO;
          end else begin
            do_err     = 1'b1;
            err_code_n = 2'd0;
            state_n    = S_IDLE;
          end
        end
        S_CNT_LO: state_n = S_CNT_HI;
        S_CNT_HI: begin
          if (frame_bytes > seg_limit) begin
            do_err     = 1'b1;
            err_code_n = 2'd1;
            state_n    = S_IDLE;
          end else if ({in_data, cnt[7:0]} == 16'd0) begin
            state_n = S_CHK;
          end else begin
            hold_set = 1'b1;
            state_n  = S_DATA;
          end
        end
        S_DATA: begin
          if (bcnt == 2'd3) begin
            do_write = 1'b1;
            if (16'(idx + 16'd1) == cnt) state_n = S_CHK;
          end
        end
        S_CHK: begin
          if (in_data == xsum) begin
            do_done = 1'b1;
          end else begin
            do_err     = 1'b1;
            err_code_n = 2'd2;
          end
          state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Frame datapath: running XOR, counters, word assembly and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg       <= 1'b0;
      cnt       <= 16'd0;
      idx       <= 16'd0;
      bcnt      <= 2'd0;
      word_lo   <= 24'd0;
      xsum      <= 8'd0;
      mem_we    <= 1'b0;
      mem_seg   <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      core_hold <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      mem_we   <= do_write;
      done     <= do_done;
      err      <= do_err;
      err_code <= do_err ? err_code_n : 2'd0;
      if (hold_set)     core_hold <= 1'b1;
      else if (do_done) core_hold <= 1'b0;
      if (do_write) begin
        mem_seg   <= seg;
        mem_addr  <= (seg ? DATA_ORG_W : TEXT_ORG_W) + {14'd0, idx, 2'b00};
        mem_wdata <= {in_data, word_lo};
      end
      if (in_valid) begin
        case (state)
          S_IDLE: if (in_data == SYNC_BYTE) xsum <= 8'd0;
          S_SEG: begin
            xsum <= xsum ^ in_data;
            if (in_data[7:1] == 7'd0) seg <= in_data[0];
          end
          S_CNT_LO: begin
            xsum     <= xsum ^ in_data;
            cnt[7:0] <= in_data;
          end
          S_CNT_HI: begin
            xsum      <= xsum ^ in_data;
            cnt[15:8] <= in_data;
            idx       <= 16'd0;
            bcnt      <= 2'd0;
          end
          S_DATA: begin
            xsum <= xsum ^ in_data;
            bcnt <= bcnt + 2'd1;
            case (bcnt)
              2'd0:    word_lo[7:0]   <= in_data;
              2'd1:    word_lo[15:8]  <= in_data;
              2'd2:    word_lo[23:16] <= in_data;
              default: idx            <= idx + 16'd1;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed and random frame streams checked against a frame-level model
module tb_prog_loader;

  localparam int TLEN = 'h400;
  localparam int DLEN = 'h400;
  localparam int TORG = 'h0;
  localparam int DORG = 'h500;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready, mem_we, mem_seg, core_hold, done, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  err_code;

  typedef struct {
    logic        seg;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_w[$];
  wr_t        got_w[$];
  int         exp_r[$];   // 0..3 = err_code, 4 = done
  int         got_r[$];
  logic [7:0] stream[$];
  logic       m_hold = 1'b1;
  int         vectors = 0;
  int         miscompares = 0;

  prog_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_seg(mem_seg), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) got_w.push_back('{mem_seg, mem_addr, mem_wdata});
    if (done)   got_r.push_back(4);
    if (err)    got_r.push_back(int'(err_code));
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Frame-level reference: scan for SYNC, parse the header, emit writes and the outcome.
  task automatic model();
    int i, n, sg, k;
    logic [7:0] x;
    i = 0;
    while (i < stream.size()) begin
      if (stream[i] != SYNC) begin i++; continue; end
      sg = int'(stream[i+1]);
      x  = stream[i+1];
      i += 2;
      if (sg > 1) begin exp_r.push_back(0); continue; end
      n = int'(stream[i]) + 256 * int'(stream[i+1]);
      x = x ^ stream[i] ^ stream[i+1];
      i += 2;
      if (n * 4 > (sg == 1 ? DLEN : TLEN)) begin exp_r.push_back(1); continue; end
      if (n > 0) m_hold = 1'b1;
      for (k = 0; k < n; k++) begin
        exp_w.push_back('{1'(sg), 32'((sg == 1 ? DORG : TORG) + 4 * k),
                          {stream[i+3], stream[i+2], stream[i+1], stream[i]}});
        x = x ^ stream[i] ^ stream[i+1] ^ stream[i+2] ^ stream[i+3];
        i += 4;
      end
      if (stream[i] == x) begin exp_r.push_back(4); m_hold = 1'b0; end
      else exp_r.push_back(2);
      i++;
    end
  endtask

  task automatic add_junk(input int count);
    logic [7:0] b;
    for (int j = 0; j < count; j++) begin
      b = 8'($urandom_range(0, 255));
      if (b == SYNC) b = 8'h00;
      stream.push_back(b);
    end
  endtask

  // Appends a frame; bad segments and oversized counts end at the byte that errors.
  task automatic add_frame(input int sg, input int n, input int chk_delta);
    logic [7:0] x, b;
    stream.push_back(SYNC);
    stream.push_back(8'(sg));
    if (sg > 1) return;
    stream.push_back(8'(n));
    stream.push_back(8'(n >> 8));
    if (n * 4 > (sg == 1 ? DLEN : TLEN)) return;
    x = 8'(sg) ^ 8'(n) ^ 8'(n >> 8);
    for (int j = 0; j < 4 * n; j++) begin
      b = 8'($urandom_range(0, 255));
      x = x ^ b;
      stream.push_back(b);
    end
    stream.push_back(x + 8'(chk_delta));
  endtask

  task automatic drive_stream(input int max_gap);
    int gap;
    for (int j = 0; j < stream.size(); j++) begin
      in_valid = 1'b1;
      in_data  = stream[j];
      @(posedge clk); #1;
      in_valid = 1'b0;
      gap = $urandom_range(0, max_gap);
      for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
    end
    for (int g = 0; g < 6; g++) begin @(posedge clk); #1; end
  endtask

  task automatic compare(input string tag);
    int nw, nr;
    check({tag, ".wr_count"}, 64'(got_w.size()), 64'(exp_w.size()));
    nw = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
    for (int k = 0; k < nw; k++) begin
      check({tag, ".wr_seg"},  64'(got_w[k].seg),  64'(exp_w[k].seg));
      check({tag, ".wr_addr"}, 64'(got_w[k].addr), 64'(exp_w[k].addr));
      check({tag, ".wr_data"}, 64'(got_w[k].data), 64'(exp_w[k].data));
    end
    check({tag, ".result_count"}, 64'(got_r.size()), 64'(exp_r.size()));
    nr = (got_r.size() < exp_r.size()) ? got_r.size() : exp_r.size();
    for (int k = 0; k < nr; k++) check({tag, ".result"}, 64'(got_r[k]), 64'(exp_r[k]));
    check({tag, ".core_hold"}, 64'(core_hold), 64'(m_hold));
    exp_w.delete(); got_w.delete(); exp_r.delete(); got_r.delete(); stream.delete();
  endtask

  task automatic run(input string tag, input int max_gap);
    model();
    drive_stream(max_gap);
    compare(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".in_ready"},  64'(in_ready),  64'(1));
    check({tag, ".core_hold"}, 64'(core_hold), 64'(1));
    check({tag, ".mem_we"},    64'(mem_we),    64'(0));
    check({tag, ".mem_seg"},   64'(mem_seg),   64'(0));
    check({tag, ".mem_addr"},  64'(mem_addr),  64'(0));
    check({tag, ".mem_wdata"}, 64'(mem_wdata), 64'(0));
    check({tag, ".done"},      64'(done),      64'(0));
    check({tag, ".err"},       64'(err),       64'(0));
    check({tag, ".err_code"},  64'(err_code),  64'(0));
  endtask

  initial begin
    int sg, n, kind;
    for (int g = 0; g < 3; g++) begin @(posedge clk); #1; end
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Two-word text image.
    stream = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
    run("text2", 0);

    // One-word data image; address and data must then hold.
    stream = '{8'hA5, 8'h01, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    run("data1", 1);
    check("hold.mem_addr",  64'(mem_addr),  64'h500);
    check("hold.mem_wdata", 64'(mem_wdata), 64'hDEADBEEF);

    // 257 words overflow, then a normal frame.
    stream = '{8'hA5, 8'h00, 8'h01, 8'h01};
    add_frame(0, 2, 0);
    run("overflow", 1);

    // Bad segment, then a checksum off by one.
    stream = '{8'hA5, 8'h02};
    add_frame(0, 1, 1);
    run("badseg_badchk", 0);

    // Leading junk and a zero-length frame.
    stream = '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
    run("junk_zero", 2);

    // Exactly full segments: 256 words are accepted.
    add_frame(1, 256, 0);
    run("full_data", 0);

    // Random frames, including SYNC values inside payload.
    for (int f = 0; f < 40; f++) begin
      add_junk($urandom_range(0, 3));
      kind = $urandom_range(0, 9);
      sg   = (kind == 0) ? $urandom_range(2, 255) : $urandom_range(0, 1);
      n    = (kind == 1) ? $urandom_range(257, 300) : $urandom_range(0, 6);
      add_frame(sg, n, (kind == 2) ? $urandom_range(1, 255) : 0);
      run("random", 2);
    end

    // Reset after two of four data bytes: no write, reset values.
    stream = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22};
    drive_stream(0);
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_reset_outputs("midreset");
    check("midreset.wr_count", 64'(got_w.size()), 64'(0));
    rst = 1'b0;
    m_hold = 1'b1;
    stream.delete(); got_w.delete(); got_r.delete();
    add_frame(0, 1, 0);
    run("after_reset", 1);

`ifdef LOADER_TIMEOUT_EN
    // Stall mid-DATA until the timeout fires.
    stream = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22};
    drive_stream(0);
    for (int g = 0; g < 1010; g++) begin @(posedge clk); #1; end
    m_hold = 1'b1;
    exp_r.push_back(3);
    stream.delete();
    compare("timeout");
    add_frame(1, 1, 0);
    run("after_timeout", 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
